// File: rtl/scs8hd_clkdiv_gate.sv
// Glitch-free programmable clock divider/gate feeding the clkbuf_16 tree root.
// X toggles every DIV+1 cycles; start/stop and divide changes happen only at phase boundaries.
module scs8hd_clkdiv_gate #(
    parameter int unsigned DIV_W   = 4,
    parameter int unsigned DIV_RST = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             DIV_REQ,
    output logic             DIV_ACK,
    output logic             X,
    output logic             ACTIVE
);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             x_d, ack_d, active_d;
    logic             terminal, fall, apply;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_div_q  <= DIV_INIT;
            pend_div_q <= DIV_INIT;
            pend_vld_q <= 1'b0;
            X          <= 1'b0;
            DIV_ACK    <= 1'b0;
            ACTIVE     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            X          <= x_d;
            DIV_ACK    <= ack_d;
            ACTIVE     <= active_d;
        end
    end

    // Next-state, phase counter and divide-change handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        x_d        = X;
        ack_d      = 1'b0;
        fall       = 1'b0;
        apply      = 1'b0;
        terminal   = (cnt_q == cur_div_q);

        case (state_q)
            IDLE: begin
                x_d   = 1'b0;
                cnt_d = '0;
                if (EN) state_d = RUN;
            end
            RUN: begin
                if (!EN && !X) begin
                    // Truncating the low phase cannot produce a runt pulse
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (terminal) begin
                    x_d   = ~X;
                    cnt_d = '0;
                    if (X) begin
                        fall = 1'b1;
                        if (!EN) state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                    if (!EN) state_d = STOP;
                end
            end
            STOP: begin
                // High phase always completes; EN is not looked at here
                if (terminal) begin
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    fall    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase

        apply = pend_vld_q && (fall || (state_q == IDLE));
        if (apply) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end
        // A request coinciding with an apply is kept for the next boundary
        if (DIV_REQ) begin
            pend_div_d = DIV;
            pend_vld_d = 1'b1;
        end

        active_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_scs8hd_clkdiv_gate.sv
// Directed bench for scs8hd_clkdiv_gate (DIV_W=4, DIV_RST=2 so reset half-period is 3).
module tb_scs8hd_clkdiv_gate;

    localparam int unsigned DIV_W = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             EN;
    logic [DIV_W-1:0] DIV;
    logic             DIV_REQ;
    logic             DIV_ACK;
    logic             X;
    logic             ACTIVE;

    int errors = 0;
    int checks = 0;

    scs8hd_clkdiv_gate #(.DIV_W(DIV_W), .DIV_RST(2)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .DIV     (DIV),
        .DIV_REQ (DIV_REQ),
        .DIV_ACK (DIV_ACK),
        .X       (X),
        .ACTIVE  (ACTIVE)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle past it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; EN = 1'b1; DIV = '0; DIV_REQ = 1'b1;
        step();
        step();
        RESET = 1'b0; EN = 1'b0; DIV_REQ = 1'b0;
        checks++; if (X !== 1'b0)       begin errors++; $display("FAIL reset_x: X=%b expected 0", X); end
        checks++; if (ACTIVE !== 1'b0)  begin errors++; $display("FAIL reset_active: ACTIVE=%b expected 0", ACTIVE); end
        checks++; if (DIV_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: DIV_ACK=%b expected 0", DIV_ACK); end
    endtask

    // H=3 start, then EN dropped one cycle after X rises
    task automatic test_start_stop_h3();
        logic [2:0] ex_start;
        logic [3:0] ex_x, ex_act;
        ex_start = 3'b100;
        ex_x     = 4'b0011;
        ex_act   = 4'b0011;
        EN = 1'b1;
        step();
        checks++; if (ACTIVE !== 1'b1) begin errors++; $display("FAIL h3_active_start: ACTIVE=%b expected 1", ACTIVE); end
        checks++; if (X !== 1'b0)      begin errors++; $display("FAIL h3_x_start: X=%b expected 0", X); end
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (X !== ex_start[e-1]) begin errors++; $display("FAIL h3_rise edge %0d: X=%b expected %b", e, X, ex_start[e-1]); end
        end
        EN = 1'b0;
        for (int e = 4; e <= 7; e++) begin
            step();
            checks++;
            if (X !== ex_x[e-4]) begin errors++; $display("FAIL h3_stop_x edge %0d: X=%b expected %b", e, X, ex_x[e-4]); end
            checks++;
            if (ACTIVE !== ex_act[e-4]) begin errors++; $display("FAIL h3_stop_active edge %0d: ACTIVE=%b expected %b", e, ACTIVE, ex_act[e-4]); end
        end
    endtask

    // Request in IDLE acks two cycles later; then H=1 run and a low-phase stop
    task automatic test_idle_req_h1();
        logic [3:0] ex_x;
        ex_x = 4'b0101;
        DIV = 4'd0; DIV_REQ = 1'b1;
        step();
        DIV_REQ = 1'b0;
        checks++; if (DIV_ACK !== 1'b0) begin errors++; $display("FAIL idle_ack_early: DIV_ACK=%b expected 0", DIV_ACK); end
        step();
        checks++; if (DIV_ACK !== 1'b1) begin errors++; $display("FAIL idle_ack: DIV_ACK=%b expected 1", DIV_ACK); end
        checks++; if (X !== 1'b0)       begin errors++; $display("FAIL idle_x: X=%b expected 0", X); end
        step();
        checks++; if (DIV_ACK !== 1'b0) begin errors++; $display("FAIL idle_ack_width: DIV_ACK=%b expected 0", DIV_ACK); end
        EN = 1'b1;
        step();
        checks++; if (ACTIVE !== 1'b1) begin errors++; $display("FAIL h1_active: ACTIVE=%b expected 1", ACTIVE); end
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (X !== ex_x[e-1]) begin errors++; $display("FAIL h1_toggle edge %0d: X=%b expected %b", e, X, ex_x[e-1]); end
        end
        EN = 1'b0;
        step();
        checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL h1_low_stop: ACTIVE=%b expected 0", ACTIVE); end
        checks++; if (X !== 1'b0)      begin errors++; $display("FAIL h1_low_stop_x: X=%b expected 0", X); end
    endtask

    // Back to H=3, change to H=2 mid high phase, then two requests where the last wins
    task automatic test_div_change();
        logic [2:0] ex_start;
        logic [5:0] ex_x, ex_ack;
        logic [6:0] lw_x, lw_ack;
        ex_start = 3'b100;
        ex_x     = 6'b011001;
        ex_ack   = 6'b000010;
        lw_x     = 7'b1010110;
        lw_ack   = 7'b0001000;
        DIV = 4'd2; DIV_REQ = 1'b1;
        step();
        DIV_REQ = 1'b0;
        step();
        checks++; if (DIV_ACK !== 1'b1) begin errors++; $display("FAIL chg_idle_ack: DIV_ACK=%b expected 1", DIV_ACK); end
        EN = 1'b1;
        step();
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (X !== ex_start[e-1]) begin errors++; $display("FAIL chg_rise edge %0d: X=%b expected %b", e, X, ex_start[e-1]); end
        end
        DIV = 4'd1; DIV_REQ = 1'b1;
        step();
        DIV_REQ = 1'b0;
        checks++; if (X !== 1'b1) begin errors++; $display("FAIL chg_hold edge 4: X=%b expected 1", X); end
        for (int e = 5; e <= 10; e++) begin
            step();
            checks++;
            if (X !== ex_x[e-5]) begin errors++; $display("FAIL chg_x edge %0d: X=%b expected %b", e, X, ex_x[e-5]); end
            checks++;
            if (DIV_ACK !== ex_ack[e-5]) begin errors++; $display("FAIL chg_ack edge %0d: DIV_ACK=%b expected %b", e, DIV_ACK, ex_ack[e-5]); end
        end
        for (int e = 11; e <= 17; e++) begin
            DIV_REQ = (e == 11 || e == 12);
            DIV     = (e == 11) ? 4'd5 : 4'd0;
            step();
            checks++;
            if (X !== lw_x[e-11]) begin errors++; $display("FAIL lastwin_x edge %0d: X=%b expected %b", e, X, lw_x[e-11]); end
            checks++;
            if (DIV_ACK !== lw_ack[e-11]) begin errors++; $display("FAIL lastwin_ack edge %0d: DIV_ACK=%b expected %b", e, DIV_ACK, lw_ack[e-11]); end
        end
        DIV_REQ = 1'b0;
        EN = 1'b0;
        step();
        checks++; if (X !== 1'b0)      begin errors++; $display("FAIL h1_high_stop_x: X=%b expected 0", X); end
        checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL h1_high_stop_active: ACTIVE=%b expected 0", ACTIVE); end
    endtask

    // Maximum divide (H=16) and a reset that truncates the high phase
    task automatic test_max_div_reset();
        logic [2:0] ex_x;
        logic       exp;
        ex_x = 3'b100;
        DIV = 4'd15; DIV_REQ = 1'b1;
        step();
        DIV_REQ = 1'b0;
        step();
        checks++; if (DIV_ACK !== 1'b1) begin errors++; $display("FAIL max_ack: DIV_ACK=%b expected 1", DIV_ACK); end
        EN = 1'b1;
        step();
        for (int e = 1; e <= 50; e++) begin
            exp = ((e / 16) % 2) == 1;
            step();
            checks++;
            if (X !== exp) begin errors++; $display("FAIL max_x edge %0d: X=%b expected %b", e, X, exp); end
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++; if (X !== 1'b0)      begin errors++; $display("FAIL rst_mid_x: X=%b expected 0", X); end
        checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL rst_mid_active: ACTIVE=%b expected 0", ACTIVE); end
        step();
        checks++; if (ACTIVE !== 1'b1) begin errors++; $display("FAIL rst_restart_active: ACTIVE=%b expected 1", ACTIVE); end
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (X !== ex_x[e-1]) begin errors++; $display("FAIL rst_div_restore edge %0d: X=%b expected %b", e, X, ex_x[e-1]); end
        end
        EN = 1'b0;
        step();
        step();
    endtask

    initial begin
        RESET = 1'b1; EN = 1'b0; DIV = '0; DIV_REQ = 1'b0;
        test_reset();
        test_start_stop_h3();
        test_idle_req_h1();
        test_div_change();
        test_max_div_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
